seg7_seq_monitor: RTL and testbench
===================================

Name: seg7_seq_monitor

Overview:
- Receive end of the BCD-counter 7-segment display path.
- Samples the 7-segment drive, decodes it back to a BCD digit and checks that successive samples follow the mod-10 counting sequence.
- Reports lock status, sequence errors and illegal patterns.
- Used as an on-chip checker beside the counter/display block and as a bench scoreboard.

Parameters:
LOCK_N, 4, consecutive correct increments required to enter LOCKED (legal range 1-15)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
seg_in  input  7  segment drive, active-high; seg_in[0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g
sample  input  1  one-cycle strobe; seg_in is evaluated only in cycles where sample=1
digit_out  output  4  last decoded BCD digit
digit_valid  output  1  one-cycle pulse: a legal pattern was decoded
seq_err  output  1  one-cycle pulse: legal digit out of sequence while LOCKED
bad_pattern  output  1  one-cycle pulse: sampled pattern is not a legal digit
err_count  output  ERR_W  saturating count of seq_err plus bad_pattern events raised while LOCKED
locked  output  1  high while FSM is in LOCKED

Behaviour:
- Reset (async assert, sync release): outputs and state are cleared as follows.
  - digit_out=0, digit_valid=0, seq_err=0, bad_pattern=0, err_count=0, locked=0.
  - state=HUNT, expected=0, match_cnt=0.
- Legal patterns, in hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Every other value, including 00 (blank), is illegal.
- Latency: all outputs are registered. The response to a sample in cycle N is visible after the edge ending cycle N. Pulses last exactly one cycle.
- sample=0: no state change, all pulses deasserted, digit_out holds its value.
- Legal sample: digit_out <= d, digit_valid pulses. expected tracks the next value in the sequence, with 9 wrapping to 0 (legal, not an error).
- Illegal sample: bad_pattern pulses, digit_out holds.
- FSM states: HUNT, CHECK, LOCKED.
- HUNT:
  - legal d -> CHECK, expected=(d+1)%10, match_cnt=0.
  - illegal -> stay in HUNT.
- CHECK:
  - legal d==expected -> match_cnt+1, expected advances. If the new match_cnt==LOCK_N -> LOCKED.
  - legal d!=expected -> stay in CHECK, expected=(d+1)%10, match_cnt=0. seq_err is not raised.
  - illegal -> HUNT.
- LOCKED:
  - legal d==expected -> stay in LOCKED, expected advances.
  - legal d!=expected -> seq_err pulses, err_count increments, -> CHECK with expected=(d+1)%10, match_cnt=0.
  - illegal -> bad_pattern pulses, err_count increments, -> HUNT.
- err_count saturates at 2^ERR_W-1 and never wraps. Events outside LOCKED do not increment it.
- locked is a registered copy of (state==LOCKED). With LOCK_N=4, locked rises after the edge of the 5th consecutive in-sequence sample (first sample plus 4 matches).
- Reset asserted mid-operation clears everything immediately, including a pulse in flight. The first sample after release is treated as in HUNT.
- Only one event is possible per sample. seq_err and bad_pattern are never high together.

Test Plan:
1. Reset, LOCK_N=4; strobe digits 0..9,0,1 (one sample every 2 cycles) -> digit_valid pulses 12 times, digit_out tracks each digit; locked=1 after the 5th sample and stays high through the 9->0 wrap; err_count=0, no seq_err.
2. Locked at digit 3, then sample 5 -> seq_err pulses once, err_count=1, locked=0; then samples 6,7,8,9 -> locked=1 again after the 4th match.
3. Locked, then sample seg_in=7'h00 -> bad_pattern=1, seq_err=0, err_count+1, locked=0, digit_out holds its previous value; next legal sample re-enters CHECK.
4. ERR_W=2: lock, then inject 5 out-of-sequence events, re-locking between each -> err_count reads 1,2,3,3,3 (saturates); sample 7'h7F while in HUNT -> digit_out=8 and no count change.
5. Hold seg_in toggling with sample=0 for 20 cycles -> no pulses and no state/digit change; assert rst asynchronously mid-cycle while locked -> all outputs are 0 before the next clock edge.

Source files
------------

// File: rtl/seg7_seq_monitor_if.sv
// Bundle for the 7-segment monitor: sampled segment drive in, decode/check results out.
// Latency: none, wires only.
// Backpressure: none; the sample strobe is never stalled.
interface seg7_seq_monitor_if #(
  parameter int ERR_W = 8
);
  logic [6:0]       seg_in;
  logic             sample;
  logic [3:0]       digit_out;
  logic             digit_valid;
  logic             seq_err;
  logic             bad_pattern;
  logic [ERR_W-1:0] err_count;
  logic             locked;

  // Side that drives the display and consumes the check results.
  modport master (
    output seg_in, sample,
    input  digit_out, digit_valid, seq_err, bad_pattern, err_count, locked
  );

  // The monitor itself.
  modport slave (
    input  seg_in, sample,
    output digit_out, digit_valid, seq_err, bad_pattern, err_count, locked
  );
endinterface

// File: rtl/seg7_seq_monitor.sv
// Decodes sampled 7-segment drive to BCD and checks it follows the mod-10 count.
// Latency: one cycle; every output is registered off the sampling edge.
// Backpressure: none; every cycle with sample=1 is evaluated.
module seg7_seq_monitor #(
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  seg7_seq_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       expected_q, expected_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             seq_err_q, seq_err_d;
  logic             bad_q, bad_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q;

  logic             dec_legal;
  logic [3:0]       dec_digit;
  logic [3:0]       dec_next;
  logic [3:0]       match_inc;
  logic             err_evt;

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Map the segment pattern back to a digit; anything else, blank included, is illegal.
  always_comb begin
    dec_legal = 1'b1;
    dec_digit = 4'd0;
    case (mon.seg_in)
      7'h3F:   dec_digit = 4'd0;
      7'h06:   dec_digit = 4'd1;
      7'h5B:   dec_digit = 4'd2;
      7'h4F:   dec_digit = 4'd3;
      7'h66:   dec_digit = 4'd4;
      7'h6D:   dec_digit = 4'd5;
      7'h7D:   dec_digit = 4'd6;
      7'h07:   dec_digit = 4'd7;
      7'h7F:   dec_digit = 4'd8;
      7'h6F:   dec_digit = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_next  = next_digit(dec_digit);
  assign match_inc = match_q + 4'd1;

  // Next-state and pulse logic; pulses default low so they last one cycle.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    match_d    = match_q;
    digit_d    = digit_q;
    valid_d    = 1'b0;
    seq_err_d  = 1'b0;
    bad_d      = 1'b0;
    err_evt    = 1'b0;

    if (mon.sample) begin
      if (!dec_legal) begin
        // Illegal pattern: digit_out holds, sequence tracking restarts.
        bad_d   = 1'b1;
        state_d = HUNT;
        match_d = 4'd0;
        if (state_q == LOCKED) begin
          err_evt = 1'b1;
        end
      end else begin
        valid_d = 1'b1;
        digit_d = dec_digit;
        // In every legal case the next expected digit follows the one just seen:
        // on a match this is the advance, on a mismatch it is the resync.
        expected_d = dec_next;
        case (state_q)
          HUNT: begin
            state_d = CHECK;
            match_d = 4'd0;
          end
          CHECK: begin
            if (dec_digit == expected_q) begin
              match_d = match_inc;
              if (match_inc == LOCK_V) begin
                state_d = LOCKED;
              end
            end else begin
              match_d = 4'd0;
            end
          end
          LOCKED: begin
            if (dec_digit != expected_q) begin
              seq_err_d = 1'b1;
              err_evt   = 1'b1;
              state_d   = CHECK;
              match_d   = 4'd0;
            end
          end
          default: begin
            state_d = HUNT;
            match_d = 4'd0;
          end
        endcase
      end
    end
  end

  // Error counter only advances on events raised while locked and sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State and output registers; reset clears everything including in-flight pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      expected_q <= 4'd0;
      match_q    <= 4'd0;
      digit_q    <= 4'd0;
      valid_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      bad_q      <= 1'b0;
      err_cnt_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      match_q    <= match_d;
      digit_q    <= digit_d;
      valid_q    <= valid_d;
      seq_err_q  <= seq_err_d;
      bad_q      <= bad_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= (state_d == LOCKED);
    end
  end

  assign mon.digit_out   = digit_q;
  assign mon.digit_valid = valid_q;
  assign mon.seq_err     = seq_err_q;
  assign mon.bad_pattern = bad_q;
  assign mon.err_count   = err_cnt_q;
  assign mon.locked      = locked_q;

endmodule

// File: tb/tb_seg7_seq_monitor.sv
// Bench for seg7_seq_monitor: two instances (8-bit and 2-bit error counters) driven identically.
// Latency: outputs compared 1ns after the sampling edge against a history-based model.
// Backpressure: none.
module tb_seg7_seq_monitor;
  localparam int LOCK_N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_seq_monitor_if #(.ERR_W(8)) bus8 ();
  seg7_seq_monitor_if #(.ERR_W(2)) bus2 ();

  seg7_seq_monitor #(.LOCK_N(LOCK_N), .ERR_W(8)) u_dut8 (.clk(clk), .rst(rst), .mon(bus8.slave));
  seg7_seq_monitor #(.LOCK_N(LOCK_N), .ERR_W(2)) u_dut2 (.clk(clk), .rst(rst), .mon(bus2.slave));

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_lut [10];

  // Model: the checker's condition is a function of the recent sample history.
  // m_run = length of the current run of consecutive legal samples each one more
  // (mod 10) than the previous; locked means the run is longer than LOCK_N.
  int m_digit;
  int m_run;
  int m_err;
  bit m_vld, m_seq, m_bad;

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (seg_lut[i] == s) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_digit = 0; m_run = 0; m_err = 0;
    m_vld = 0; m_seq = 0; m_bad = 0;
  endtask

  task automatic model_sample(input logic [6:0] s);
    int d;
    bit was_locked;
    d = decode(s);
    was_locked = (m_run > LOCK_N);
    m_vld = 0; m_seq = 0; m_bad = 0;
    if (d < 0) begin
      m_bad = 1;
      if (was_locked) m_err++;
      m_run = 0;
    end else begin
      m_vld = 1;
      if (m_run > 0 && d == (m_digit + 1) % 10) begin
        m_run++;
        if (m_run > LOCK_N + 1) m_run = LOCK_N + 1;
      end else begin
        if (was_locked) begin
          m_seq = 1;
          m_err++;
        end
        m_run = 1;
      end
      m_digit = d;
    end
  endtask

  function automatic logic [18:0] exp_vec();
    int e8, e2;
    bit lk;
    e8 = (m_err > 255) ? 255 : m_err;
    e2 = (m_err > 3) ? 3 : m_err;
    lk = (m_run > LOCK_N);
    return {4'(m_digit), m_vld, m_seq, m_bad, 8'(e8), 2'(e2), lk, lk};
  endfunction

  function automatic logic [18:0] obs();
    return {bus8.digit_out, bus8.digit_valid, bus8.seq_err, bus8.bad_pattern,
            bus8.err_count, bus2.err_count, bus8.locked, bus2.locked};
  endfunction

  // One clock: drive at the falling edge, look 1ns after the rising edge.
  task automatic cycle(input logic [6:0] s, input logic smp);
    @(negedge clk);
    bus8.seg_in = s; bus8.sample = smp;
    bus2.seg_in = s; bus2.sample = smp;
    @(posedge clk);
    #1;
    if (smp) model_sample(s);
    else begin
      m_vld = 0; m_seq = 0; m_bad = 0;
    end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    bus8.seg_in = 7'h00; bus8.sample = 1'b0;
    bus2.seg_in = 7'h00; bus2.sample = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.seg_in = 7'h3F; bus8.sample = 1'b1;
    bus2.seg_in = 7'h3F; bus2.sample = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if (obs() !== 19'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs(), 19'h0);
    end
    checks++;
    @(negedge clk);
    bus8.sample = 1'b0; bus2.sample = 1'b0;
    rst = 1'b0;
    cycle(7'h00, 1'b0);
    if (obs() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_count_lock();
    int vcount;
    vcount = 0;
    reset_all();
    for (int i = 0; i < 12; i++) begin
      cycle(seg_lut[i % 10], 1'b1);
      vcount += int'(bus8.digit_valid);
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL count_lock sample %0d: got %h expected %h", i, obs(), exp_vec());
      end
      checks++;
      cycle(7'($urandom), 1'b0);
      vcount += int'(bus8.digit_valid);
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL count_lock gap %0d: got %h expected %h", i, obs(), exp_vec());
      end
      checks++;
    end
    if (vcount != 12) begin
      errors++;
      $display("FAIL count_lock valid_pulses: got %0d expected 12", vcount);
    end
    checks++;
  endtask

  task automatic test_seq_error();
    int seq [7] = '{2, 3, 5, 6, 7, 8, 9};
    for (int i = 0; i < 7; i++) begin
      cycle(seg_lut[seq[i]], 1'b1);
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL seq_error digit %0d: got %h expected %h", seq[i], obs(), exp_vec());
      end
      checks++;
      cycle(7'h00, 1'b0);
    end
  endtask

  task automatic test_bad_pattern();
    logic [6:0] pats [3];
    pats[0] = seg_lut[0];
    pats[1] = 7'h00;
    pats[2] = seg_lut[4];
    for (int i = 0; i < 3; i++) begin
      cycle(pats[i], 1'b1);
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL bad_pattern step %0d: got %h expected %h", i, obs(), exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_saturation();
    reset_all();
    for (int i = 0; i <= LOCK_N; i++) cycle(seg_lut[i], 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(seg_lut[(m_digit + 3) % 10], 1'b1);
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL saturation jump %0d: got %h expected %h", k, obs(), exp_vec());
      end
      checks++;
      for (int j = 0; j < LOCK_N; j++) begin
        cycle(seg_lut[(m_digit + 1) % 10], 1'b1);
        if (obs() !== exp_vec()) begin
          errors++;
          $display("FAIL saturation relock %0d.%0d: got %h expected %h", k, j, obs(), exp_vec());
        end
        checks++;
      end
    end
    cycle(7'h00, 1'b1);
    if (obs() !== exp_vec()) begin
      errors++;
      $display("FAIL saturation blank: got %h expected %h", obs(), exp_vec());
    end
    checks++;
    cycle(7'h7F, 1'b1);
    if (obs() !== exp_vec()) begin
      errors++;
      $display("FAIL saturation hunt_eight: got %h expected %h", obs(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i <= LOCK_N; i++) cycle(seg_lut[(m_digit + 1) % 10], 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(7'($urandom), 1'b0);
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: got %h expected %h", i, obs(), exp_vec());
      end
      checks++;
    end
    cycle(seg_lut[(m_digit + 1) % 10], 1'b1);
    if (obs() !== exp_vec()) begin
      errors++;
      $display("FAIL idle_resume: got %h expected %h", obs(), exp_vec());
    end
    checks++;
    // Reset lands mid-cycle while locked with digit_valid still high.
    #2;
    rst = 1'b1;
    #1;
    if (obs() !== 19'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs(), 19'h0);
    end
    checks++;
    model_reset();
    bus8.sample = 1'b0; bus2.sample = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(seg_lut[5], 1'b1);
    if (obs() !== exp_vec()) begin
      errors++;
      $display("FAIL post_reset_hunt: got %h expected %h", obs(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_random();
    logic [6:0] s;
    int r;
    int gap;
    reset_all();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 75)      s = seg_lut[(m_digit + 1) % 10];
      else if (r < 88) s = seg_lut[$urandom_range(9)];
      else             s = 7'($urandom);
      cycle(s, 1'b1);
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL random sample %0d seg %h: got %h expected %h", i, s, obs(), exp_vec());
      end
      checks++;
      gap = $urandom_range(2);
      for (int g = 0; g < gap; g++) begin
        cycle(7'($urandom), 1'b0);
        if (obs() !== exp_vec()) begin
          errors++;
          $display("FAIL random gap %0d: got %h expected %h", i, obs(), exp_vec());
        end
        checks++;
      end
    end
  endtask

  initial begin
    seg_lut[0] = 7'h3F; seg_lut[1] = 7'h06; seg_lut[2] = 7'h5B; seg_lut[3] = 7'h4F;
    seg_lut[4] = 7'h66; seg_lut[5] = 7'h6D; seg_lut[6] = 7'h7D; seg_lut[7] = 7'h07;
    seg_lut[8] = 7'h7F; seg_lut[9] = 7'h6F;
    test_reset();
    test_count_lock();
    test_seq_error();
    test_bad_pattern();
    test_saturation();
    test_idle_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
